// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin arbiter sharing one add/sub datapath between two requesters
module addsub_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic             req0_m_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic             req1_m_i,

    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic [WIDTH-1:0] rsp0_sum_o,
    output logic             rsp0_carry_o,
    output logic             rsp0_ovf_o,

    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [WIDTH-1:0] rsp1_sum_o,
    output logic             rsp1_carry_o,
    output logic             rsp1_ovf_o,

    output logic [WIDTH-1:0] dp_a_o,
    output logic [WIDTH-1:0] dp_b_o,
    output logic             dp_m_o,
    input  logic [WIDTH-1:0] dp_sum_i,
    input  logic             dp_carry_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   prio_q, prio_d;
    logic                   gnt_q, gnt_d;
    logic [WIDTH-1:0]       reg_a_q, reg_a_d;
    logic [WIDTH-1:0]       reg_b_q, reg_b_d;
    logic                   reg_m_q, reg_m_d;
    logic [1:0]             rsp_valid_q, rsp_valid_d;
    logic [1:0][WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
    logic [1:0]             rsp_carry_q, rsp_carry_d;
    logic [1:0]             rsp_ovf_q, rsp_ovf_d;

    logic                   grant;
    logic                   accept;
    logic                   ovf;
    logic                   rsp_ready_gnt;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        grant = req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant = prio_q;
        end
    end

    assign req0_ready_o  = (state_q == IDLE) & req0_valid_i & ~grant;
    assign req1_ready_o  = (state_q == IDLE) & req1_valid_i & grant;
    assign accept        = req0_ready_o | req1_ready_o;
    assign rsp_ready_gnt = gnt_q ? rsp1_ready_i : rsp0_ready_i;

    // Overflow: effective operand signs agree but the result sign differs from A.
    assign ovf = (reg_a_q[WIDTH-1] ~^ (reg_b_q[WIDTH-1] ^ reg_m_q))
               & (dp_sum_i[WIDTH-1] ^ reg_a_q[WIDTH-1]);

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        reg_a_d     = reg_a_q;
        reg_b_d     = reg_b_q;
        reg_m_d     = reg_m_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        rsp_ovf_d   = rsp_ovf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    gnt_d   = grant;
                    reg_a_d = grant ? req1_a_i : req0_a_i;
                    reg_b_d = grant ? req1_b_i : req0_b_i;
                    reg_m_d = grant ? req1_m_i : req0_m_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rsp_sum_d[gnt_q]   = dp_sum_i;
                rsp_carry_d[gnt_q] = dp_carry_i;
                rsp_ovf_d[gnt_q]   = ovf;
                rsp_valid_d[gnt_q] = 1'b1;
                state_d            = RESP;
            end
            RESP: begin
                if (rsp_ready_gnt) begin
                    rsp_valid_d[gnt_q] = 1'b0;
                    prio_d             = ~gnt_q;
                    state_d            = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            gnt_q       <= 1'b0;
            reg_a_q     <= '0;
            reg_b_q     <= '0;
            reg_m_q     <= 1'b0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= '0;
            rsp_ovf_q   <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            gnt_q       <= gnt_d;
            reg_a_q     <= reg_a_d;
            reg_b_q     <= reg_b_d;
            reg_m_q     <= reg_m_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign dp_a_o       = reg_a_q;
    assign dp_b_o       = reg_b_q;
    assign dp_m_o       = reg_m_q;

    assign rsp0_valid_o = rsp_valid_q[0];
    assign rsp0_sum_o   = rsp_sum_q[0];
    assign rsp0_carry_o = rsp_carry_q[0];
    assign rsp0_ovf_o   = rsp_ovf_q[0];

    assign rsp1_valid_o = rsp_valid_q[1];
    assign rsp1_sum_o   = rsp_sum_q[1];
    assign rsp1_carry_o = rsp_carry_q[1];
    assign rsp1_ovf_o   = rsp_ovf_q[1];

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed-vector bench for addsub_arbiter with a behavioural adder/subtractor
module tb_addsub_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_m = 1'b0, req1_m = 1'b0;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [3:0] rsp0_sum, rsp1_sum;
    logic       rsp0_carry, rsp1_carry, rsp0_ovf, rsp1_ovf;
    logic [3:0] dp_a, dp_b, dp_sum;
    logic       dp_m, dp_carry;
    logic [4:0] dp_full;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Ripple-carry adder/subtractor stand-in: A + (B ^ m) + m.
    always_comb begin
        dp_full  = {1'b0, dp_a} + {1'b0, dp_b ^ {4{dp_m}}} + {4'b0, dp_m};
        dp_sum   = dp_full[3:0];
        dp_carry = dp_full[4];
    end

    addsub_arbiter #(.WIDTH(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req0_m_i     (req0_m),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .req1_m_i     (req1_m),
        .rsp0_valid_o (rsp0_valid),
        .rsp0_ready_i (rsp0_ready),
        .rsp0_sum_o   (rsp0_sum),
        .rsp0_carry_o (rsp0_carry),
        .rsp0_ovf_o   (rsp0_ovf),
        .rsp1_valid_o (rsp1_valid),
        .rsp1_ready_i (rsp1_ready),
        .rsp1_sum_o   (rsp1_sum),
        .rsp1_carry_o (rsp1_carry),
        .rsp1_ovf_o   (rsp1_ovf),
        .dp_a_o       (dp_a),
        .dp_b_o       (dp_b),
        .dp_m_o       (dp_m),
        .dp_sum_i     (dp_sum),
        .dp_carry_i   (dp_carry)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " readies"}, {30'b0, req1_ready, req0_ready}, 0);
        check({tag, " rsp valids"}, {30'b0, rsp1_valid, rsp0_valid}, 0);
        check({tag, " rsp data"}, {22'b0, rsp1_sum, rsp1_carry, rsp1_ovf, rsp0_sum, rsp0_carry, rsp0_ovf}, 0);
        check({tag, " dp"}, {23'b0, dp_a, dp_b, dp_m}, 0);
    endtask

    // Single operation on requester n with rsp_ready high; checks 3-cycle timing and results.
    task automatic run_op(input logic n, input logic [3:0] a, input logic [3:0] b, input logic m,
                          input logic [3:0] es, input logic ec, input logic eo, input string tag);
        if (n) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_m = m; end
        else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_m = m; end
        #1;
        check({tag, " ready c0"}, n ? req1_ready : req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, " valid c1"}, n ? rsp1_valid : rsp0_valid, 0);
        check({tag, " dp_a c1"}, dp_a, a);
        tick();
        check({tag, " valid c2"}, n ? rsp1_valid : rsp0_valid, 1);
        check({tag, " sum"}, n ? rsp1_sum : rsp0_sum, es);
        check({tag, " carry"}, n ? rsp1_carry : rsp0_carry, ec);
        check({tag, " ovf"}, n ? rsp1_ovf : rsp0_ovf, eo);
        tick();
        check({tag, " valid c3"}, n ? rsp1_valid : rsp0_valid, 0);
    endtask

    logic       grants [8];
    int         cycs   [8];
    int         n_acc;
    logic [3:0] held_sum;

    initial begin
        #1;
        check_all_zero("reset");
        tick();
        rst = 1'b0;

        run_op(1'b0, 4'd5, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0, "op0 5-3");
        run_op(1'b1, 4'd7, 4'd1, 1'b0, 4'b1000, 1'b0, 1'b1, "op1 7+1");
        run_op(1'b1, 4'd3, 4'd5, 1'b1, 4'b1110, 1'b0, 1'b0, "op1 3-5");

        // Fairness from reset: both valid continuously.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_m = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd1; req1_m = 1'b1;
        #1;
        n_acc = 0;
        for (int c = 0; c < 40 && n_acc < 8; c++) begin
            if (req0_ready || req1_ready) begin
                grants[n_acc] = req1_ready;
                cycs[n_acc]   = c;
                n_acc++;
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("fair accept count", n_acc, 8);
        for (int i = 0; i < 8; i++) begin
            if (i < n_acc) begin
                check($sformatf("fair grant %0d", i), grants[i], i % 2);
                if (i > 0) check($sformatf("fair spacing %0d", i), cycs[i] - cycs[i-1], 3);
            end
        end
        repeat (3) tick();
        check("fair drained", {30'b0, rsp1_valid, rsp0_valid}, 0);

        // Backpressure: rsp0 held for 5 cycles, req1 waiting.
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3; req0_m = 1'b0;
        #1;
        check("bp accept", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd4; req1_m = 1'b1;
        tick();
        check("bp valid", rsp0_valid, 1);
        held_sum = rsp0_sum;
        check("bp sum", rsp0_sum, 4'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp hold valid %0d", i), rsp0_valid, 1);
            check($sformatf("bp hold data %0d", i), {rsp0_sum, rsp0_carry, rsp0_ovf}, {held_sum, 2'b00});
            check($sformatf("bp readies %0d", i), {30'b0, req1_ready, req0_ready}, 0);
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        check("bp released", rsp0_valid, 0);
        check("bp idle req1 ready", req1_ready, 1);

        // Reset during ISSUE of the req1 operation (9-4).
        tick();
        req1_valid = 1'b0;
        check("rst pre issue", dp_a, 4'd9);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst mid");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst no rsp1 %0d", i), rsp1_valid, 0);
            tick();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst prio req0", {30'b0, req1_ready, req0_ready}, 2'b01);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // req0 pulses while req1 is in flight.
        req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd4; req1_m = 1'b0;
        #1;
        check("pulse req1 accept", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd6; req0_m = 1'b0;
        #1;
        check("pulse req0 blocked", req0_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("pulse rsp1", {27'b0, rsp1_valid, rsp1_sum, rsp1_carry, rsp1_ovf} >> 0, {27'b0, 1'b1, 4'b1000, 1'b0, 1'b1});
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pulse no rsp0 %0d", i), {30'b0, rsp1_valid, rsp0_valid}, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
